hazard_unit_mc: RTL

- Parametrised successor to the pipeline hazard unit for the 5-stage MIPS core.
- Adds everything the single-cycle-execute version lacks: configurable register-address width, a jump/branch D-stage flush, and a scoreboard/countdown for one multi-cycle execute unit (multiplier).
- Sits beside the datapath and controller. It produces all forwarding selects, stalls and flushes, and tracks the in-flight multi-cycle result.

---
 rtl/hazard_unit_mc.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc
//   Hazard unit for the 5-stage MIPS core. It generates the E-stage forwarding
//   selects, the D-stage compare forwards, the stall/flush controls and a small
//   scoreboard for the one multi-cycle execute unit (multiplier).
//
// Ports
//   clk, reset                        clock (rising edge), async active-low reset
//   rs_d, rt_d, rs_e, rt_e            D/E-stage source registers
//   write_reg_{e,m,w}, reg_write_{e,m,w}  destination and write enable per stage
//   mem_to_reg_e, mem_to_reg_m        load in E / M
//   branch_d, jump_d, pc_src_d        D-stage branch, jump, branch taken
//   mul_d, mul_start_e                mul in D, mul entering execute
//   forward_ae/be                     00 RF, 01 W, 10 M ALU, 11 mul result
//   forward_ad/bd                     D-stage compare forward from M
//   stall_f, stall_d, flush_d, flush_e  pipeline control
//   mul_busy, mul_done, mul_dest      multi-cycle unit status
//   mul_overrun                       sticky: mul started while unit was busy
//
// state | meaning
// IDLE  | no multi-cycle op in flight
// BUSY  | op executing, counter counts down to 0
// DONE  | result on the mul writeback bus (held while W-stage owns the port)
module hazard_unit_mc #(
    parameter int REG_AW  = 5,
    parameter int MUL_LAT = 4,
    parameter int CW      = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] rs_d,
    input  logic [REG_AW-1:0] rt_d,
    input  logic [REG_AW-1:0] rs_e,
    input  logic [REG_AW-1:0] rt_e,
    input  logic [REG_AW-1:0] write_reg_e,
    input  logic [REG_AW-1:0] write_reg_m,
    input  logic [REG_AW-1:0] write_reg_w,
    input  logic              reg_write_e,
    input  logic              reg_write_m,
    input  logic              reg_write_w,
    input  logic              mem_to_reg_e,
    input  logic              mem_to_reg_m,
    input  logic              branch_d,
    input  logic              jump_d,
    input  logic              pc_src_d,
    input  logic              mul_d,
    input  logic              mul_start_e,
    output logic [1:0]        forward_ae,
    output logic [1:0]        forward_be,
    output logic              forward_ad,
    output logic              forward_bd,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_d,
    output logic              flush_e,
    output logic              mul_busy,
    output logic              mul_done,
    output logic [REG_AW-1:0] mul_dest,
    output logic              mul_overrun
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    // BUSY lasts MUL_LAT-1 cycles (counter values MUL_LAT-2 .. 0), DONE follows.
    localparam logic [CW-1:0] LP_CNT_INIT = CW'(MUL_LAT - 2);

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic              r_mul_busy;
    logic              r_mul_done;
    logic [REG_AW-1:0] r_mul_dest;
    logic              r_mul_overrun;

    logic w_lwstall;
    logic w_branchstall;
    logic w_mulstall;
    logic w_wbstall;
    logic w_stall;

    // Nonzero destination matching either D-stage source.
    function automatic logic hits(input logic [REG_AW-1:0] dst,
                                  input logic [REG_AW-1:0] a,
                                  input logic [REG_AW-1:0] b);
        return (dst != '0) && ((dst == a) || (dst == b));
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src);
        logic [1:0] sel;
        sel = 2'b00;
        if (src != '0) begin
            if (r_mul_done && (src == r_mul_dest))
                sel = 2'b11;
            else if (reg_write_m && (write_reg_m == src))
                sel = 2'b10;
            else if (reg_write_w && (write_reg_w == src))
                sel = 2'b01;
        end
        return sel;
    endfunction

    always_comb begin
        forward_ae = fwd_sel(rs_e);
        forward_be = fwd_sel(rt_e);
        forward_ad = reg_write_m && (rs_d != '0) && (write_reg_m == rs_d);
        forward_bd = reg_write_m && (rt_d != '0) && (write_reg_m == rt_d);

        w_lwstall     = mem_to_reg_e && hits(write_reg_e, rs_d, rt_d);
        w_branchstall = branch_d &&
                        ((reg_write_e  && hits(write_reg_e, rs_d, rt_d)) ||
                         (mem_to_reg_m && hits(write_reg_m, rs_d, rt_d)));
        w_mulstall    = (r_state == S_BUSY) &&
                        (mul_d || hits(r_mul_dest, rs_d, rt_d));
        // Writeback port conflict: W-stage write wins, mul result is retried.
        w_wbstall     = r_mul_done && reg_write_w;
        w_stall       = w_lwstall || w_branchstall || w_mulstall || w_wbstall;

        stall_f = w_stall;
        stall_d = w_stall;
        flush_e = w_stall;
        flush_d = (jump_d || (branch_d && pc_src_d)) && !w_stall;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_mul_busy    <= 1'b0;
            r_mul_done    <= 1'b0;
            r_mul_dest    <= '0;
            r_mul_overrun <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (mul_start_e) begin
                        r_mul_dest <= write_reg_e;
                        r_cnt      <= LP_CNT_INIT;
                        r_mul_busy <= 1'b1;
                        r_state    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (mul_start_e)
                        r_mul_overrun <= 1'b1;
                    if (r_cnt == '0) begin
                        r_mul_done <= 1'b1;
                        r_state    <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    if (reg_write_w) begin
                        // Result still pending; a new start cannot be taken.
                        if (mul_start_e)
                            r_mul_overrun <= 1'b1;
                    end else if (mul_start_e) begin
                        r_mul_dest <= write_reg_e;
                        r_cnt      <= LP_CNT_INIT;
                        r_mul_done <= 1'b0;
                        r_state    <= S_BUSY;
                    end else begin
                        r_mul_done <= 1'b0;
                        r_mul_busy <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_mul_done <= 1'b0;
                    r_mul_busy <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign mul_busy    = r_mul_busy;
    assign mul_done    = r_mul_done;
    assign mul_dest    = r_mul_dest;
    assign mul_overrun = r_mul_overrun;

endmodule
